// File: rtl/sram_march_bist_if.sv
// SRAM command/data bus between the march BIST controller (master) and a single-port SRAM (slave).
interface sram_march_bist_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int WMASK_WIDTH = DATA_WIDTH / 8;

  logic                   sram_csb;
  logic                   sram_web;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport master (
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

  modport slave (
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram_march_bist.sv
// Two-pass (write all, read/compare all) SRAM BIST; reads compared one cycle after issue.
// A pass run takes 2*2^ADDR_WIDTH+2 cycles; the first mismatch aborts the run straight to DONE.
module sram_march_bist #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  sram_march_bist_if.master     sram
);
  localparam int WMASK_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            mode_q, mode_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  mismatch;

  always_comb begin
    pattern = '0;
    case (mode_q)
      2'd0:    pattern = {WMASK_WIDTH{8'h55}};
      2'd1:    pattern = addr_q[0] ? {WMASK_WIDTH{8'hAA}} : {WMASK_WIDTH{8'h55}};
      2'd2:    pattern = DATA_WIDTH'(addr_q);
      default: pattern = ~DATA_WIDTH'(addr_q);
    endcase
  end

  assign mismatch = cmp_vld_q && (sram.sram_dout != cmp_exp_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    cmp_vld_d   = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    cmp_exp_d   = cmp_exp_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d      = mode_i;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          addr_d      = '0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_READ: begin
        // Remember what this read must return; sram_dout arrives next cycle.
        cmp_vld_d  = 1'b1;
        cmp_addr_d = addr_q;
        cmp_exp_d  = pattern;
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort on the first mismatch; address is frozen so the idle bus stays stable.
    if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_data_d = sram.sram_dout;
      addr_d      = addr_q;
      cmp_vld_d   = 1'b0;
      state_d     = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mode_q      <= 2'd0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy_o      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

  assign sram.sram_csb   = !((state_q == S_WRITE) || (state_q == S_READ));
  assign sram.sram_web   = (state_q != S_WRITE);
  assign sram.sram_wmask = (state_q == S_WRITE) ? '1 : '0;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_din   = (state_q == S_WRITE) ? pattern : '0;
endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench: directed + random vectors against a pattern/fault reference model.
module tb_sram_march_bist;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1, start = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic           busy, done, fail;
  logic [AW-1:0]  fail_addr;
  logic [DW-1:0]  fail_data;

  logic           reset_s = 1'b1, start_s = 1'b0;
  logic [1:0]     mode_s = 2'd0;
  logic           busy_s, done_s, fail_s;
  logic [1:0]     fail_addr_s;
  logic [7:0]     fail_data_s;

  sram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  sram_march_bist_if #(.ADDR_WIDTH(2),  .DATA_WIDTH(8))  ifb ();

  sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start_i(start), .mode_i(mode),
    .busy_o(busy), .done_o(done), .fail_o(fail),
    .fail_addr_o(fail_addr), .fail_data_o(fail_data), .sram(ifa)
  );

  sram_march_bist #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut_s (
    .clk(clk), .reset(reset_s), .start_i(start_s), .mode_i(mode_s),
    .busy_o(busy_s), .done_o(done_s), .fail_o(fail_s),
    .fail_addr_o(fail_addr_s), .fail_data_o(fail_data_s), .sram(ifb)
  );

  // SRAM models: read data valid the cycle after the command; optional single stuck-inverted bit.
  logic [DW-1:0] mem_a [N];
  logic [7:0]    mem_b [4];
  bit            fault_en = 1'b0;
  int            fault_addr = 0, fault_bit = 0;

  always @(posedge clk) begin
    if (!ifa.sram_csb) begin
      if (!ifa.sram_web) begin
        for (int i = 0; i < DW / 8; i++)
          if (ifa.sram_wmask[i]) mem_a[ifa.sram_addr][8*i +: 8] <= ifa.sram_din[8*i +: 8];
      end else begin
        ifa.sram_dout <= mem_a[ifa.sram_addr] ^
          ((fault_en && int'(ifa.sram_addr) == fault_addr) ? (32'h1 << fault_bit) : 32'h0);
      end
    end
  end

  always @(posedge clk) begin
    if (!ifb.sram_csb) begin
      if (!ifb.sram_web) mem_b[ifb.sram_addr] <= ifb.sram_din;
      else               ifb.sram_dout <= mem_b[ifb.sram_addr];
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic logic [DW-1:0] pat(input logic [1:0] m, input int a);
    case (m)
      2'd0:    return {4{8'h55}};
      2'd1:    return (a % 2 == 1) ? {4{8'hAA}} : {4{8'h55}};
      2'd2:    return DW'(a);
      default: return ~DW'(a);
    endcase
  endfunction

  // Reference: writes land intact, the read of address a is issued at cycle N+1+a,
  // compared in the following cycle and, if wrong, DONE follows one cycle later.
  task automatic ref_run(input logic [1:0] m, input bit fe, input int fa, input int fb,
                         output bit f, output int faddr, output logic [DW-1:0] fdata,
                         output int dcyc);
    logic [DW-1:0] want, got;
    f = 1'b0; faddr = 0; fdata = '0; dcyc = 2 * N + 2;
    for (int a = 0; a < N; a++) begin
      want = pat(m, a);
      got  = want ^ ((fe && a == fa) ? (32'h1 << fb) : 32'h0);
      if (got != want) begin
        f = 1'b1; faddr = a; fdata = got; dcyc = N + 3 + a;
        break;
      end
    end
  endtask

  logic [DW-1:0] wdat [N];

  task automatic run_a(input logic [1:0] m, input bit hold, output int dcyc, output int nwr,
                       output int nrd, output int seq_err, output int rd_cyc);
    @(negedge clk);
    start = 1'b1; mode = m;
    dcyc = -1; nwr = 0; nrd = 0; seq_err = 0; rd_cyc = -1;
    for (int k = 1; k <= 3000 && dcyc < 0; k++) begin
      @(negedge clk);
      if (!hold) begin
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
      end else if (k == 50) begin
        mode = ~m;
      end
      if (k == 1 && fail) seq_err++;
      if (!ifa.sram_csb) begin
        if (!ifa.sram_web) begin
          if (int'(ifa.sram_addr) != k - 1 || ifa.sram_din != pat(m, k - 1) || ifa.sram_wmask != 4'hF)
            seq_err++;
          wdat[ifa.sram_addr] = ifa.sram_din;
          nwr++;
        end else begin
          if (int'(ifa.sram_addr) != k - N - 1 || ifa.sram_wmask != 4'h0) seq_err++;
          if (fault_en && int'(ifa.sram_addr) == fault_addr) rd_cyc = k;
          nrd++;
        end
      end
      if (done) begin
        dcyc = k;
        if (busy || !ifa.sram_csb) seq_err++;
      end else if (!busy) begin
        seq_err++;
      end
    end
  endtask

  typedef struct {
    logic [1:0]    mode;
    bit            fe;
    int            fa;
    int            fb;
    bit            exp_fail;
    int            exp_addr;
    logic [DW-1:0] exp_data;
    int            exp_done;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    int dcyc, nwr, nrd, serr, rcyc, exp_nrd, dones, cmds;
    bit rf;
    int ra, rd;
    logic [DW-1:0] rdat;

    vecs[0] = '{2'd0, 1'b0, 0,    0,  1'b0, 0,    32'h0,        514};
    vecs[1] = '{2'd1, 1'b0, 0,    0,  1'b0, 0,    32'h0,        514};
    vecs[2] = '{2'd2, 1'b1, 'h17, 3,  1'b1, 'h17, 32'h0000001F, 282};
    vecs[3] = '{2'd3, 1'b0, 0,    0,  1'b0, 0,    32'h0,        514};
    vecs[4] = '{2'd3, 1'b1, 0,    31, 1'b1, 0,    32'h7FFFFFFF, 259};
    vecs[5] = '{2'd0, 1'b1, 'hFF, 0,  1'b1, 'hFF, 32'h55555554, 514};
    for (int i = 6; i < NV; i++) begin
      vecs[i].mode = 2'($urandom_range(0, 3));
      vecs[i].fe   = 1'($urandom_range(0, 1));
      vecs[i].fa   = int'($urandom_range(0, N - 1));
      vecs[i].fb   = int'($urandom_range(0, DW - 1));
      ref_run(vecs[i].mode, vecs[i].fe, vecs[i].fa, vecs[i].fb, rf, ra, rdat, rd);
      vecs[i].exp_fail = rf; vecs[i].exp_addr = ra; vecs[i].exp_data = rdat; vecs[i].exp_done = rd;
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_data", fail_data, 0);
    check("rst_csb", ifa.sram_csb, 1);
    check("rst_web", ifa.sram_web, 1);
    check("rst_wmask", ifa.sram_wmask, 0);
    check("rst_addr", ifa.sram_addr, 0);
    check("rst_din", ifa.sram_din, 0);
    reset = 1'b0; reset_s = 1'b0;

    for (int i = 0; i < NV; i++) begin
      fault_en = vecs[i].fe; fault_addr = vecs[i].fa; fault_bit = vecs[i].fb;
      run_a(vecs[i].mode, 1'b0, dcyc, nwr, nrd, serr, rcyc);
      exp_nrd = vecs[i].exp_fail ? ((vecs[i].exp_addr + 2 > N) ? N : vecs[i].exp_addr + 2) : N;
      check($sformatf("v%0d done_cycle", i), dcyc, vecs[i].exp_done);
      check($sformatf("v%0d fail", i), fail, vecs[i].exp_fail);
      check($sformatf("v%0d fail_addr", i), fail_addr, vecs[i].exp_addr);
      check($sformatf("v%0d fail_data", i), fail_data, vecs[i].exp_data);
      check($sformatf("v%0d writes", i), nwr, N);
      check($sformatf("v%0d reads", i), nrd, exp_nrd);
      check($sformatf("v%0d bus_seq_errors", i), serr, 0);
      if (vecs[i].mode == 2'd1) begin
        check($sformatf("v%0d m1_word0", i), wdat[0], 32'h55555555);
        check($sformatf("v%0d m1_word1", i), wdat[1], 32'hAAAAAAAA);
      end
      if (vecs[i].mode == 2'd3) begin
        check($sformatf("v%0d m3_word0", i), wdat[0], 32'hFFFFFFFF);
        check($sformatf("v%0d m3_word1", i), wdat[1], 32'hFFFFFFFE);
      end
      if (vecs[i].fe && vecs[i].fa == 'h17 && vecs[i].mode == 2'd2)
        check($sformatf("v%0d read17_cycle", i), rcyc, 280);
      @(negedge clk);
      check($sformatf("v%0d done_one_cycle", i), done, 0);
    end
    fault_en = 1'b0;

    // Reset in the middle of the write pass.
    @(negedge clk);
    start = 1'b1; mode = 2'd0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_csb", ifa.sram_csb, 1);
    check("midrst_done", done, 0);
    dones = 0; cmds = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (!ifa.sram_csb) cmds++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_no_cmds", cmds, 0);
    run_a(2'd2, 1'b0, dcyc, nwr, nrd, serr, rcyc);
    check("midrst_rerun_done", dcyc, 514);
    check("midrst_rerun_fail", fail, 0);
    check("midrst_rerun_seq", serr, 0);

    // start held high for the whole run, mode flipped mid-run.
    repeat (3) @(negedge clk);
    run_a(2'd2, 1'b1, dcyc, nwr, nrd, serr, rcyc);
    check("hold_done_cycle", dcyc, 514);
    check("hold_seq_errors", serr, 0);
    check("hold_writes", nwr, N);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    check("hold_idle_done", done, 0);
    @(negedge clk);
    check("hold_rerun_busy", busy, 1);
    check("hold_rerun_write", {ifa.sram_csb, ifa.sram_web}, 2'b00);
    check("hold_rerun_addr", ifa.sram_addr, 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Narrow instance: 4 words, 8-bit data, mode 2.
    begin
      int dcyc_s, nwr_s, nrd_s, err_s;
      @(negedge clk);
      start_s = 1'b1; mode_s = 2'd2;
      dcyc_s = -1; nwr_s = 0; nrd_s = 0; err_s = 0;
      for (int k = 1; k <= 40 && dcyc_s < 0; k++) begin
        @(negedge clk);
        start_s = 1'b0;
        if (!ifb.sram_csb && !ifb.sram_web) begin
          if (int'(ifb.sram_addr) != k - 1 || int'(ifb.sram_din) != k - 1 || ifb.sram_wmask != 1'b1)
            err_s++;
          nwr_s++;
        end
        if (!ifb.sram_csb && ifb.sram_web) nrd_s++;
        if (done_s) dcyc_s = k;
      end
      check("small_done_cycle", dcyc_s, 10);
      check("small_writes", nwr_s, 4);
      check("small_reads", nrd_s, 4);
      check("small_write_errors", err_s, 0);
      check("small_fail", fail_s, 0);
      check("small_mem3", mem_b[3], 8'h03);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=time limit reached required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_march_bist.md
SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: SRAM address width; the test covers all 2^ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, multiple of 8: SRAM word width.
REQ-003 Derived localparam WMASK_WIDTH = DATA_WIDTH/8, default 4.
REQ-004 clk  input  1: single clock; all state SHALL change on rising edge only.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start  input  1: request a test run; sampled only in IDLE.
REQ-007 mode  input  2: data pattern select; sampled with start.
REQ-008 busy  output  1: high while the test runs (WRITE, READ, DRAIN).
REQ-009 done  output  1: one-cycle pulse at end of run, pass or fail.
REQ-010 fail  output  1: sticky mismatch flag; cleared on next accepted start or reset.
REQ-011 fail_addr  output  ADDR_WIDTH: address of first mismatch.
REQ-012 fail_data  output  DATA_WIDTH: data actually read at first mismatch.
REQ-013 sram_csb  output  1: SRAM chip select, active-low.
REQ-014 sram_web  output  1: SRAM write enable, active-low.
REQ-015 sram_wmask  output  WMASK_WIDTH: byte write mask.
REQ-016 sram_addr  output  ADDR_WIDTH: SRAM address.
REQ-017 sram_din  output  DATA_WIDTH: SRAM write data.
REQ-018 sram_dout  input  DATA_WIDTH: SRAM read data, valid the cycle after the read command.

Function
REQ-019 States SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-020 IDLE with start=1: latch mode, clear fail/fail_addr/fail_data, go to WRITE with address 0.
REQ-021 WRITE: one write per cycle, sram_csb=0, sram_web=0, sram_wmask all ones, addresses ascending 0 to 2^ADDR_WIDTH-1; after the last address go to READ with address 0.
REQ-022 READ: one read per cycle, sram_csb=0, sram_web=1, sram_wmask=0, addresses ascending; after the last address go to DRAIN.
REQ-023 The expected word and address of each read SHALL be registered; sram_dout SHALL be compared one cycle after issue (in READ or DRAIN).
REQ-024 DRAIN: sram_csb=1; compare the final read; then go to DONE.
REQ-025 On mismatch: set fail; capture the compared address into fail_addr and sram_dout into fail_data; next state DONE (abort); no further SRAM commands.
REQ-026 Only the first mismatch SHALL be captured.
REQ-027 DONE: done=1 for exactly one cycle, sram_csb=1; next state IDLE.
REQ-028 Patterns by address a: mode 0 = 0x55 repeated; mode 1 = 0xAA repeated for odd a, 0x55 repeated for even a; mode 2 = a zero-extended to DATA_WIDTH; mode 3 = bitwise inverse of the mode-2 value.
REQ-029 The address counter SHALL be ADDR_WIDTH bits; the terminal count is all ones; no wrap-around write or read SHALL occur.
REQ-030 start outside IDLE SHALL be ignored; mode changes during a run SHALL have no effect.
REQ-031 A pass run SHALL take 2*2^ADDR_WIDTH+2 cycles from the start-sample edge to the done pulse.

Reset
REQ-032 reset SHALL force IDLE from any state (mid-run included) on the next edge, with outputs as in REQ-033.
REQ-033 After reset: busy=0, done=0, fail=0, fail_addr=0, fail_data=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
REQ-034 With sram_csb=1, the values of sram_web, sram_addr and sram_din SHALL be don't-care but SHALL be held stable.

Verification
REQ-035 Default parameters, ideal SRAM model, mode 0, start pulsed at cycle 0 -> 256 writes of 0x55555555, 256 reads, done at cycle 514, fail=0.
REQ-036 Mode 2, model bit 3 of word 0x17 stuck inverted -> read of 0x17 issued at cycle 280, done at cycle 282, fail=1, fail_addr=0x17, fail_data=0x0000001F.
REQ-037 Modes 1 and 3 -> write data checked: addr 0x00 gets 0x55555555 and 0xFFFFFFFF; addr 0x01 gets 0xAAAAAAAA and 0xFFFFFFFE.
REQ-038 reset asserted at cycle 100 (mid-WRITE) -> next cycle IDLE, sram_csb=1, busy=0, no done pulse; a new start then runs a full pass.
REQ-039 start held high across a whole run, mode toggled mid-run -> one run only, original mode used, done once; a second run starts the cycle after DONE since start is still high.
REQ-040 ADDR_WIDTH=2, DATA_WIDTH=8, mode 2 -> addresses 0..3 written with 0x00..0x03, no address wrap, done at cycle 10.
